// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the instruction-cycle sequencer.
package pc_seq_pkg;

   localparam int unsigned PC_W_DEF = 8;
   localparam int unsigned IR_W_DEF = 12;
   localparam int unsigned STAGE_W  = 3;

   localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = 8'h00;

   typedef enum logic [STAGE_W-1:0] {
      ST_LOAD    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_HALTED  = 3'd4
   } stage_e;

endpackage

// File: rtl/pc_seq_incrementer.sv
// Combinational W-bit +1 with carry-out; carry marks the all-ones -> zero wrap.
module pc_incrementer #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] sum,
   output logic         carry
);

   localparam int unsigned SW = W + 1;

   assign {carry, sum} = {1'b0, a} + SW'(1);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: LOAD -> FETCH -> DECODE -> EXECUTE, owns pc and ir.
// Optional trap on pc wrap enabled by defining PC_WRAP_TRAP_EN.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned    PC_W     = PC_W_DEF,
   parameter int unsigned    IR_W     = IR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_done,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic [IR_W-1:0]     imem_data,
   input  logic                imem_valid,
   input  logic                jump_en,
   input  logic [PC_W-1:0]     jump_addr,
   input  logic                halt,
   output logic [PC_W-1:0]     pc,
   output logic [IR_W-1:0]     ir,
   output logic [STAGE_W-1:0]  stage
`ifdef PC_WRAP_TRAP_EN
   ,
   output logic                pc_wrap
`endif
);

   stage_e            state_q, state_d;
   logic [PC_W-1:0]   pc_d;
   logic [IR_W-1:0]   ir_d;
   logic              req_d;
   logic [PC_W-1:0]   pc_inc;
   logic              pc_carry;
`ifdef PC_WRAP_TRAP_EN
   logic              wrap_d;
`endif

   pc_incrementer #(.W(PC_W)) u_inc (
      .a     (pc),
      .sum   (pc_inc),
      .carry (pc_carry)
   );

   // Next-state, next-pc and next-ir decode.
   always_comb begin
      state_d = state_q;
      pc_d    = pc;
      ir_d    = ir;
`ifdef PC_WRAP_TRAP_EN
      wrap_d  = pc_wrap;
`endif
      unique case (state_q)
         ST_LOAD: begin
            if (load_done) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_valid) begin
               ir_d    = imem_data;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (jump_en) begin
               pc_d    = jump_addr;
               state_d = ST_FETCH;
            end else begin
`ifdef PC_WRAP_TRAP_EN
               if (pc_carry) begin
                  wrap_d  = 1'b1;
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_inc;
                  state_d = ST_FETCH;
               end
`else
               pc_d    = pc_carry ? '0 : pc_inc;
               state_d = ST_FETCH;
`endif
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
      // Request is a registered decode of the FETCH state.
      req_d = (state_d == ST_FETCH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_LOAD;
         pc       <= RESET_PC;
         ir       <= '0;
         imem_req <= 1'b0;
`ifdef PC_WRAP_TRAP_EN
         pc_wrap  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc       <= pc_d;
         ir       <= ir_d;
         imem_req <= req_d;
`ifdef PC_WRAP_TRAP_EN
         pc_wrap  <= wrap_d;
`endif
      end
   end

   assign imem_addr = pc;
   assign stage     = STAGE_W'(state_q);

endmodule
